// File: rtl/axi_crossbar_slv_sync_if_if.sv
// axi_crossbar_slv_sync_if_if: switch-side channel bus and AXI3 slave bus used by the sync slave port adapter
interface xbar_sw_if #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32
);
    localparam int AXCH_W = AXI_ADDR_W + AXI_ID_W + 11;
    localparam int WCH_W  = AXI_DATA_W + AXI_DATA_W / 8 + AXI_ID_W;
    localparam int BCH_W  = AXI_ID_W + 2;
    localparam int RCH_W  = AXI_DATA_W + AXI_ID_W + 2;
    logic              awvalid, awready;
    logic [AXCH_W-1:0] awch;
    logic              wvalid, wready, wlast;
    logic [WCH_W-1:0]  wch;
    logic              bvalid, bready;
    logic [BCH_W-1:0]  bch;
    logic              arvalid, arready;
    logic [AXCH_W-1:0] arch;
    logic              rvalid, rready, rlast;
    logic [RCH_W-1:0]  rch;
    modport master (
        output awvalid, awch, wvalid, wlast, wch, bready, arvalid, arch, rready,
        input  awready, wready, bvalid, bch, arready, rvalid, rlast, rch
    );
    modport slave (
        input  awvalid, awch, wvalid, wlast, wch, bready, arvalid, arch, rready,
        output awready, wready, bvalid, bch, arready, rvalid, rlast, rch
    );
endinterface

interface axi3_slv_if #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32
);
    logic [AXI_ID_W-1:0]     awid, wid, bid, arid, rid;
    logic [AXI_ADDR_W-1:0]   awaddr, araddr;
    logic [3:0]              awlen, arlen;
    logic [2:0]              awsize, arsize;
    logic [1:0]              awburst, awlock, arburst, arlock, bresp, rresp;
    logic                    awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic                    arvalid, arready, rvalid, rready, rlast;
    logic [AXI_DATA_W-1:0]   wdata, rdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_crossbar_slv_sync_if.sv
// axi_crossbar_slv_sync_if: single-clock switch-to-AXI3-slave adapter with per-channel FIFOs, base subtraction, outstanding limits; AXI_SLV_IF_WGATE_EN holds W behind its AW
module axi_crossbar_slv_sync_if_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         i_aclk,
    input  logic         i_srst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(D);
    logic [W-1:0] mem_q [D];
    logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
    logic         empty_q, empty_d, full_q, full_d, do_push, do_pop;
    // advance pointers on accepted push/pop; empty/full derived from the next pointers so they can be registered
    always_comb begin
        do_push = push & ~full_q;
        do_pop  = pop & ~empty_q;
        wp_d    = wp_q + {{AW{1'b0}}, do_push};
        rp_d    = rp_q + {{AW{1'b0}}, do_pop};
        empty_d = wp_d == rp_d;
        full_d  = wp_d == {~rp_d[AW], rp_d[AW-1:0]};
    end
    // pointer and flag registers
    always_ff @(posedge i_aclk) begin
        if (i_srst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end
    // storage; contents need no reset because empty masks them
    always_ff @(posedge i_aclk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
    end
    assign ready = ~full_q;
    assign valid = ~empty_q;
    assign dout  = mem_q[rp_q[AW-1:0]];
endmodule

module axi_crossbar_slv_sync_if #(
    parameter int                    AXI_ADDR_W       = 32,
    parameter int                    AXI_ID_W         = 4,
    parameter int                    AXI_DATA_W       = 32,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR        = '0,
    parameter int                    SLV_OSTDREQ_NUM  = 4,
    parameter int                    SLV_OSTDREQ_SIZE = 1
) (
    input  logic                                   i_aclk,
    input  logic                                   i_srst,
    xbar_sw_if.slave                               sw,
    axi3_slv_if.master                             axi,
    output logic [$clog2(SLV_OSTDREQ_NUM+1)-1:0]   o_wr_ostd,
    output logic [$clog2(SLV_OSTDREQ_NUM+1)-1:0]   o_rd_ostd
);
    localparam int AXCH_W = AXI_ADDR_W + AXI_ID_W + 11;
    localparam int WCH_W  = AXI_DATA_W + AXI_DATA_W / 8 + AXI_ID_W;
    localparam int BCH_W  = AXI_ID_W + 2;
    localparam int RCH_W  = AXI_DATA_W + AXI_ID_W + 2;
    localparam int DDEP   = SLV_OSTDREQ_NUM * SLV_OSTDREQ_SIZE;
    localparam int CW     = $clog2(SLV_OSTDREQ_NUM + 1);
    logic              aw_rdy, aw_vld, w_rdy, w_vld, ar_rdy, ar_vld;
    logic [AXCH_W-1:0] aw_dout, ar_dout;
    logic [WCH_W:0]    w_dout;
    logic [CW-1:0]     wr_ostd_q, wr_ostd_d, rd_ostd_q, rd_ostd_d;
    axi_crossbar_slv_sync_if_fifo #(.W(AXCH_W), .D(SLV_OSTDREQ_NUM)) u_aw (
        .i_aclk, .i_srst, .push(sw.awvalid & sw.awready), .pop(axi.awvalid & axi.awready),
        .din(sw.awch), .ready(aw_rdy), .valid(aw_vld), .dout(aw_dout)
    );
    axi_crossbar_slv_sync_if_fifo #(.W(WCH_W + 1), .D(DDEP)) u_w (
        .i_aclk, .i_srst, .push(sw.wvalid & sw.wready), .pop(axi.wvalid & axi.wready),
        .din({sw.wlast, sw.wch}), .ready(w_rdy), .valid(w_vld), .dout(w_dout)
    );
    axi_crossbar_slv_sync_if_fifo #(.W(BCH_W), .D(SLV_OSTDREQ_NUM)) u_b (
        .i_aclk, .i_srst, .push(axi.bvalid & axi.bready), .pop(sw.bvalid & sw.bready),
        .din({axi.bresp, axi.bid}), .ready(axi.bready), .valid(sw.bvalid), .dout(sw.bch)
    );
    axi_crossbar_slv_sync_if_fifo #(.W(AXCH_W), .D(SLV_OSTDREQ_NUM)) u_ar (
        .i_aclk, .i_srst, .push(sw.arvalid & sw.arready), .pop(axi.arvalid & axi.arready),
        .din(sw.arch), .ready(ar_rdy), .valid(ar_vld), .dout(ar_dout)
    );
    axi_crossbar_slv_sync_if_fifo #(.W(RCH_W + 1), .D(DDEP)) u_r (
        .i_aclk, .i_srst, .push(axi.rvalid & axi.rready), .pop(sw.rvalid & sw.rready),
        .din({axi.rlast, axi.rdata, axi.rresp, axi.rid}), .ready(axi.rready), .valid(sw.rvalid),
        .dout({sw.rlast, sw.rch})
    );
    assign sw.awready = aw_rdy & (wr_ostd_q < CW'(SLV_OSTDREQ_NUM));
    assign sw.arready = ar_rdy & (rd_ostd_q < CW'(SLV_OSTDREQ_NUM));
    assign sw.wready  = w_rdy;
    assign axi.awvalid = aw_vld;
    assign axi.arvalid = ar_vld;
    assign {axi.awlock, axi.awburst, axi.awsize, axi.awlen, axi.awid} = aw_dout[AXCH_W-1:AXI_ADDR_W];
    assign {axi.arlock, axi.arburst, axi.arsize, axi.arlen, axi.arid} = ar_dout[AXCH_W-1:AXI_ADDR_W];
    assign axi.awaddr = aw_dout[AXI_ADDR_W-1:0] - BASE_ADDR;
    assign axi.araddr = ar_dout[AXI_ADDR_W-1:0] - BASE_ADDR;
    assign {axi.wlast, axi.wstrb, axi.wdata, axi.wid} = w_dout;
    assign o_wr_ostd = wr_ostd_q;
    assign o_rd_ostd = rd_ostd_q;
    // outstanding counts: request accepted adds one, response completion removes one unless already zero
    always_comb begin
        wr_ostd_d = wr_ostd_q + CW'(sw.awvalid & sw.awready) - CW'(sw.bvalid & sw.bready & (wr_ostd_q != '0));
        rd_ostd_d = rd_ostd_q + CW'(sw.arvalid & sw.arready) - CW'(sw.rvalid & sw.rready & sw.rlast & (rd_ostd_q != '0));
    end
    // outstanding count registers
    always_ff @(posedge i_aclk) begin
        if (i_srst) begin
            wr_ostd_q <= '0;
            rd_ostd_q <= '0;
        end else begin
            wr_ostd_q <= wr_ostd_d;
            rd_ostd_q <= rd_ostd_d;
        end
    end
`ifdef AXI_SLV_IF_WGATE_EN
    logic [CW-1:0] awc_q, awc_d;
    // write credit: one per AW taken by the slave, returned on the matching last W beat
    always_comb awc_d = awc_q + CW'(axi.awvalid & axi.awready) - CW'(axi.wvalid & axi.wready & axi.wlast);
    // write credit register
    always_ff @(posedge i_aclk) begin
        if (i_srst) awc_q <= '0;
        else awc_q <= awc_d;
    end
    assign axi.wvalid = w_vld & (awc_q != '0);
`else
    assign axi.wvalid = w_vld;
`endif
endmodule
